// File: rtl/os_result_drain.sv
// os_result_drain: sequencer and result reader for one row of output-stationary PEs.
//
// A tile runs IDLE -> ACCUM -> END -> DRAIN -> CLEAR -> IDLE:
//   ACCUM  holds pipeline_en for k_len + NUM_PE - 1 cycles, which covers the systolic skew.
//   END    holds mac_end until every PE reports valid, then captures all PE accumulators.
//   DRAIN  streams the captured words one per valid/ready handshake, PE 0 first.
//   CLEAR  pulses reg_clear and done together for one cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start, k_len             tile launch and accumulation length, sampled in IDLE only
//   pipeline_en, mac_end     PE enable (ACCUM) and accumulation-end strobe (END)
//   reg_clear                one-cycle PE clear (CLEAR)
//   mac_is_valid, mac_in     per-PE valid bits and concatenated PE accumulators
//   out_data/idx/valid/last  result stream; out_ready is the downstream accept
//   busy, done               not-IDLE indicator and end-of-tile pulse
//
// Build option: define OS_DRAIN_SATURATE_EN to saturate words that do not fit in
// WIDTH_OUT; otherwise words are truncated to their low WIDTH_OUT bits.
//
// All outputs are decoded from registered state only, so there is no input-to-output path.
module os_result_drain #(
  parameter int unsigned WIDTH_MAC = 48,
  parameter int unsigned WIDTH_OUT = 32,
  parameter int unsigned NUM_PE    = 4,
  parameter int unsigned K_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [K_W-1:0]                k_len,
  output logic                          pipeline_en,
  output logic                          mac_end,
  output logic                          reg_clear,
  input  logic [NUM_PE-1:0]             mac_is_valid,
  input  logic [NUM_PE*WIDTH_MAC-1:0]   mac_in,
  output logic [WIDTH_OUT-1:0]          out_data,
  output logic [$clog2(NUM_PE)-1:0]     out_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned IdxW = $clog2(NUM_PE);
  // Wide enough for the largest k_len plus the skew cycles.
  localparam int unsigned CntW = K_W + IdxW + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PE - 1);

  typedef enum logic [2:0] {StIdle, StAccum, StEnd, StDrain, StClear} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [WIDTH_MAC-1:0] res_q [NUM_PE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (k_len != '0) begin
              cnt_q   <= CntW'(k_len) + CntW'(NUM_PE - 1);
              state_q <= StAccum;
            end else begin
              // Nothing to accumulate: PEs still hold their cleared values.
              state_q <= StEnd;
            end
          end
        end
        StAccum: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StEnd;
          end
        end
        StEnd: begin
          if (&mac_is_valid) begin
            for (int i = 0; i < NUM_PE; i++) begin
              res_q[i] <= mac_in[i*WIDTH_MAC +: WIDTH_MAC];
            end
            idx_q   <= '0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (idx_q == LastIdx) begin
              state_q <= StClear;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StClear: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Word conversion of the currently selected buffered accumulator.
  logic signed [WIDTH_MAC-1:0] sel;
  logic        [WIDTH_OUT-1:0] conv;

  assign sel = res_q[idx_q];

  if (WIDTH_OUT >= WIDTH_MAC) begin : g_extend
    // Signed cast sign-extends when the output is at least as wide.
    assign conv = WIDTH_OUT'(sel);
  end else begin : g_reduce
`ifdef OS_DRAIN_SATURATE_EN
    localparam logic signed [WIDTH_MAC-1:0] SatMax =
        {{(WIDTH_MAC - WIDTH_OUT + 1){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [WIDTH_MAC-1:0] SatMin =
        {{(WIDTH_MAC - WIDTH_OUT + 1){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};
    always_comb begin
      conv = WIDTH_OUT'(sel);
      if (sel > SatMax) begin
        conv = {1'b0, {(WIDTH_OUT - 1){1'b1}}};
      end else if (sel < SatMin) begin
        conv = {1'b1, {(WIDTH_OUT - 1){1'b0}}};
      end
    end
`else
    assign conv = WIDTH_OUT'(sel);
`endif
  end

  assign pipeline_en = (state_q == StAccum);
  assign mac_end     = (state_q == StEnd);
  assign reg_clear   = (state_q == StClear);
  assign done        = (state_q == StClear);
  assign busy        = (state_q != StIdle);
  assign out_valid   = (state_q == StDrain);
  assign out_idx     = out_valid ? idx_q : '0;
  assign out_last    = out_valid && (idx_q == LastIdx);
  assign out_data    = out_valid ? conv : '0;

endmodule

// File: tb/tb_os_result_drain.sv
// Self-checking bench for os_result_drain: randomized tiles checked against a
// timeline/word-list model derived from the tile parameters.
module tb_os_result_drain;

  localparam int NP = 4;
  localparam int WM = 48;
  localparam int WO = 32;
  localparam int KW = 16;
  localparam int IW = $clog2(NP);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [KW-1:0]        k_len = '0;
  logic                 pipeline_en, mac_end, reg_clear;
  logic [NP-1:0]        mac_is_valid = '0;
  logic [NP*WM-1:0]     mac_in = '0;
  logic [WO-1:0]        out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_valid, out_last, busy, done;
  logic                 out_ready = 1'b0;

  os_result_drain #(
    .WIDTH_MAC (WM),
    .WIDTH_OUT (WO),
    .NUM_PE    (NP),
    .K_W       (KW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .k_len        (k_len),
    .pipeline_en  (pipeline_en),
    .mac_end      (mac_end),
    .reg_clear    (reg_clear),
    .mac_is_valid (mac_is_valid),
    .mac_in       (mac_in),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  longint tile_vals [NP];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected streamed word for a signed accumulator value.
  function automatic longint exp_word(input longint v);
    longint r = v;
`ifdef OS_DRAIN_SATURATE_EN
    longint lmax = (longint'(1) <<< (WO - 1)) - 1;
    longint lmin = -(longint'(1) <<< (WO - 1));
    if (r > lmax) r = lmax;
    if (r < lmin) r = lmin;
`endif
    return r & ((longint'(1) <<< WO) - 1);
  endfunction

  function automatic longint all_outs();
    return longint'({pipeline_en, mac_end, reg_clear, out_data, out_idx, out_valid,
                     out_last, busy, done});
  endfunction

  task automatic rand_vals(input bit big);
    logic [63:0] t;
    for (int i = 0; i < NP; i++) begin
      if (big) begin
        t = {$urandom, $urandom};
        tile_vals[i] = longint'(t) >>> 16;  // spans the full 48-bit signed range
      end else begin
        tile_vals[i] = longint'($urandom_range(0, 2000)) - 1000;
      end
    end
  endtask

  // One tile: k = k_len, vdly = END cycles with partial valid, bp = random backpressure,
  // poke = start pulses during DRAIN, rst_at = transfers before an async reset (0 = none).
  task automatic run_tile(input int k, input int vdly, input bit bp, input bit poke,
                          input int rst_at);
    logic [63:0] t;
    int  cyc, pe_cnt, end_first, end_cnt, first_ov, nxfer, done_cnt, idle_cnt, idle_cyc;
    bit  fin, do_rst;
    for (int i = 0; i < NP; i++) begin
      t = tile_vals[i];
      mac_in[i*WM +: WM] = t[WM-1:0];
    end
    mac_is_valid = '0;
    out_ready    = 1'b1;
    start        = 1'b1;
    k_len        = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; pe_cnt = 0; end_first = -1; end_cnt = 0; first_ov = -1; nxfer = 0;
    done_cnt = 0; idle_cnt = 0; idle_cyc = -1; fin = 0; do_rst = 0;
    while (!fin && cyc < 3000) begin
      if (done_cnt > 0 && !reg_clear) begin
        // Cycle after CLEAR: back in IDLE with everything quiet.
        check_eq("post_tile_outs", all_outs(), 0);
        idle_cyc = cyc;
        fin = 1;
      end else begin
        if (!busy) idle_cnt++;
        if (pipeline_en) pe_cnt++;
        if (mac_end) begin
          if (end_first < 0) end_first = cyc;
          end_cnt++;
        end
        if (reg_clear || done) begin
          check_eq("clear_eq_done", longint'(reg_clear), longint'(done));
          done_cnt++;
        end
        if (out_valid) begin
          if (first_ov < 0) first_ov = cyc;
          if (nxfer >= NP) begin
            check_eq("extra_word", longint'(out_valid), 0);
          end else begin
            check_eq("data", longint'(out_data), exp_word(tile_vals[nxfer]));
            check_eq("idx", longint'(out_idx), longint'(nxfer));
            check_eq("last", longint'(out_last), longint'(nxfer == NP - 1));
          end
        end
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) begin
          nxfer++;
          if (rst_at > 0 && nxfer == rst_at) do_rst = 1;
        end
        mac_is_valid = (mac_end && end_cnt > vdly) ? '1 : NP'($urandom_range(0, (1 << NP) - 2));
        start = poke && out_valid && ($urandom_range(0, 1) == 1);
        k_len = KW'($urandom);
        @(posedge clk); #1;
        cyc++;
        if (do_rst) begin
          start = 1'b0;
          rst   = 1'b1;
          #1;
          check_eq("rst_mid_drain_outs", all_outs(), 0);
          check_eq("rst_no_done", longint'(done_cnt), 0);
          @(posedge clk); #1;
          rst = 1'b0;
          check_eq("rst_idle", longint'(busy), 0);
          @(posedge clk); #1;
          return;
        end
      end
    end
    start = 1'b0;
    check_eq("tile_timeout", longint'(fin), 1);
    check_eq("pe_cycles", longint'(pe_cnt), (k > 0) ? longint'(k + NP - 1) : 0);
    check_eq("mac_end_rise", longint'(end_first), (k > 0) ? longint'(k + NP) : 1);
    check_eq("mac_end_len", longint'(end_cnt), longint'(vdly + 1));
    check_eq("first_valid", longint'(first_ov), longint'(end_first + vdly + 1));
    check_eq("transfers", longint'(nxfer), NP);
    check_eq("done_pulses", longint'(done_cnt), 1);
    check_eq("busy_in_tile", longint'(idle_cnt), 0);
    if (!bp) begin
      check_eq("turnaround", longint'(idle_cyc),
               longint'(((k > 0) ? k + NP - 1 : 0) + vdly + 1 + NP + 1 + 1));
    end
  endtask

  initial begin
    #1;
    check_eq("reset_outs", all_outs(), 0);
    #20;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("idle_after_reset", all_outs(), 0);
    @(posedge clk); #1;

    tile_vals = '{10, -3, 0, 7};
    run_tile(5, 0, 0, 0, 0);
    rand_vals(0);
    run_tile(3, 0, 1, 0, 0);
    rand_vals(0);
    run_tile(2, 6, 0, 0, 0);
    tile_vals = '{longint'(1) <<< 40, -(longint'(1) <<< 40), 0, 5};
    run_tile(1, 0, 0, 0, 0);
    rand_vals(1);
    run_tile(0, 0, 1, 1, 0);
    rand_vals(0);
    run_tile(4, 1, 0, 0, 2);
    rand_vals(0);
    run_tile(4, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      rand_vals(1'($urandom_range(0, 1)));
      run_tile(int'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
